// File: rtl/ucaspian_pkg.sv
// Shared widths, sweep FSM encoding and the saturating-add helper for the
// uCaspian neuron stage.
package ucaspian_pkg;

    localparam int NEURON_ADDR_W = 8;
    localparam int CHARGE_W      = 16;
    localparam int THRESH_W      = 8;
    localparam int NUM_NEURONS   = 1 << NEURON_ADDR_W;

    // Activity-clear sweep sequencing.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // Clamp a 17-bit two's complement sum into the signed 16-bit range.
    // The two top bits differ exactly when the 16-bit result would wrap.
    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7fff;
        end
        return v[15:0];
    endfunction

endpackage

// File: rtl/ucaspian_fire_fifo.sv
// Synchronous FIFO holding the addresses of neurons that fired, waiting for
// the axon/synapse stage. Flush empties it in one cycle.
module ucaspian_fire_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    assign o_empty    = w_empty;
    assign o_free_cnt = LP_DEPTH - r_count;
    // Head reads as 0 while empty so the output is defined straight out of reset.
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // The upstream ready margin must make a lost fire impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(i_push && !i_flush && w_full && !w_pop_ok));

endmodule

// File: rtl/ucaspian_neuron.sv
// uCaspian neuron stage: accumulates dendrite charge into per-neuron
// potentials, fires on threshold crossing, queues fired addresses, and
// provides threshold configuration, activity clear and step completion.
module ucaspian_neuron
    import ucaspian_pkg::*;
#(
    parameter int FIRE_FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      clear_act,
    output logic                      clear_act_done,
    input  logic [NEURON_ADDR_W-1:0]  cfg_addr,
    input  logic [THRESH_W-1:0]       cfg_threshold,
    input  logic                      cfg_vld,
    input  logic                      dend_step_done,
    output logic                      step_done,
    input  logic [NEURON_ADDR_W-1:0]  neuron_addr,
    input  logic [CHARGE_W-1:0]       neuron_charge,
    input  logic                      neuron_vld,
    output logic                      neuron_rdy,
    output logic [NEURON_ADDR_W-1:0]  fire_addr,
    output logic                      fire_vld,
    input  logic                      fire_rdy
);

    localparam int FW = $clog2(FIRE_FIFO_DEPTH) + 1;

    // Potential and threshold memories (block RAM, registered read).
    logic [CHARGE_W-1:0] r_pot_mem [NUM_NEURONS];
    logic [THRESH_W-1:0] r_thr_mem [NUM_NEURONS];
    logic [CHARGE_W-1:0] r_pot_rd;
    logic [THRESH_W-1:0] r_thr_rd;

    // S1 stage: read data arrives alongside the latched input.
    logic                     r_s1_vld;
    logic [NEURON_ADDR_W-1:0] r_s1_addr;
    logic [CHARGE_W-1:0]      r_s1_charge;

    // Write-back stage: potential update pending this cycle.
    logic                     r_wb_vld;
    logic [NEURON_ADDR_W-1:0] r_wb_addr;
    logic [CHARGE_W-1:0]      r_wb_data;
    logic                     r_wb_fire;

    // Copy of the write that landed on the same edge as the current S1 read;
    // a read-before-write RAM returns stale data for it, so it is bypassed too.
    logic                     r_wl_vld;
    logic [NEURON_ADDR_W-1:0] r_wl_addr;
    logic [CHARGE_W-1:0]      r_wl_data;

    logic                     r_rdy;
    sweep_state_t             r_state;
    sweep_state_t             w_state_next;
    logic [NEURON_ADDR_W-1:0] r_sweep_cnt;
    logic                     r_done;

    logic                     w_accept;
    logic [CHARGE_W-1:0]      w_pot_cur;
    logic signed [16:0]       w_sum17;
    logic signed [15:0]       w_sum;
    logic                     w_fire;
    logic                     w_cfg_we;
    logic                     w_sweep_we;
    logic                     w_fifo_flush;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_fifo_empty;
    logic [NEURON_ADDR_W-1:0] w_fifo_head;
    logic [FW-1:0]            w_free_cnt;
    logic [FW-1:0]            w_free_after;
    logic                     w_rdy_next;

    assign w_accept = neuron_vld && r_rdy;
    assign w_cfg_we = cfg_vld && !enable;

    // Pick the freshest potential: pending write-back, then the write that
    // raced the read, then RAM.
    always_comb begin
        w_pot_cur = r_pot_rd;
        if (r_wl_vld && (r_wl_addr == r_s1_addr)) w_pot_cur = r_wl_data;
        if (r_wb_vld && (r_wb_addr == r_s1_addr)) w_pot_cur = r_wb_data;
    end

    assign w_sum17 = {w_pot_cur[CHARGE_W-1], w_pot_cur} + {r_s1_charge[CHARGE_W-1], r_s1_charge};
    assign w_sum   = sat16(w_sum17);
    // Threshold is unsigned, so negative sums can never fire.
    assign w_fire  = (w_sum >= $signed({{(CHARGE_W - THRESH_W){1'b0}}, r_thr_rd}));

    // Pipeline valids and data: S0 -> S1 -> write-back -> landed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_charge <= '0;
            r_wb_vld    <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_wb_fire   <= 1'b0;
            r_wl_vld    <= 1'b0;
            r_wl_addr   <= '0;
            r_wl_data   <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_addr   <= neuron_addr;
                r_s1_charge <= neuron_charge;
            end
            r_wb_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_wb_addr <= r_s1_addr;
                r_wb_data <= w_fire ? '0 : w_sum;
                r_wb_fire <= w_fire;
            end
            r_wl_vld  <= r_wb_vld;
            r_wl_addr <= r_wb_addr;
            r_wl_data <= r_wb_data;
        end
    end

    // Potential RAM: sweep zeroing and write-back never overlap (sweep waits for drain).
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_pot_mem[r_sweep_cnt] <= '0;
        end else if (r_wb_vld) begin
            r_pot_mem[r_wb_addr] <= r_wb_data;
        end
        r_pot_rd <= r_pot_mem[neuron_addr];
    end

    // Threshold RAM: written only while the stage is disabled.
    always_ff @(posedge clk) begin
        if (w_cfg_we) begin
            r_thr_mem[cfg_addr] <= cfg_threshold;
        end
        r_thr_rd <= r_thr_mem[neuron_addr];
    end

    // Sweep FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Sweep FSM next state: drain in-flight work, zero every potential, then hold.
    always_comb begin
        w_state_next = r_state;
        w_fifo_flush = 1'b0;
        w_sweep_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clear_act) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!clear_act) begin
                    w_state_next = ST_IDLE;
                end else if (!r_rdy && !r_s1_vld && !r_wb_vld) begin
                    w_state_next = ST_SWEEP;
                    w_fifo_flush = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (!clear_act) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_sweep_we = 1'b1;
                    if (r_sweep_cnt == '1) w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!clear_act) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sweep address counter (restarts at 0 on every entry) and completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sweep_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            if (r_state != ST_SWEEP) r_sweep_cnt <= '0;
            else if (w_sweep_we)     r_sweep_cnt <= r_sweep_cnt + 1'b1;
            r_done <= w_sweep_we && (r_sweep_cnt == '1);
        end
    end

    assign clear_act_done = r_done;

    assign w_push = r_wb_vld && r_wb_fire;
    assign w_pop  = fire_vld && fire_rdy;

    ucaspian_fire_fifo #(
        .DEPTH (FIRE_FIFO_DEPTH),
        .WIDTH (NEURON_ADDR_W)
    ) u_fire_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (w_fifo_flush),
        .i_push      (w_push),
        .i_push_data (r_wb_addr),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_free_cnt  (w_free_cnt)
    );

    assign fire_vld  = !w_fifo_empty;
    assign fire_addr = w_fifo_head;

    // Free slots once this cycle's push/pop settle. With S0 and S1 still able
    // to push, 3 free slots cover them plus the input accepted next cycle.
    assign w_free_after = w_free_cnt + FW'(w_pop) - FW'(w_push);
    assign w_rdy_next   = enable && !clear_act && (r_state == ST_IDLE)
                          && (w_free_after >= FW'(3));

    // Registered ready toward the dendrite.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rdy <= 1'b0;
        else          r_rdy <= w_rdy_next;
    end

    assign neuron_rdy = r_rdy;

    assign step_done = dend_step_done && !w_accept && !r_s1_vld && !r_wb_vld
                       && w_fifo_empty && !clear_act;

endmodule

// File: tb/tb_ucaspian_neuron.sv
// Randomised scoreboard bench for ucaspian_neuron: a behavioural model predicts
// fired addresses at input time; a monitor pops and compares on each fire pop.
module tb_ucaspian_neuron;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_act;
    logic        clear_act_done;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_threshold;
    logic        cfg_vld;
    logic        dend_step_done;
    logic        step_done;
    logic [7:0]  neuron_addr;
    logic [15:0] neuron_charge;
    logic        neuron_vld;
    logic        neuron_rdy;
    logic [7:0]  fire_addr;
    logic        fire_vld;
    logic        fire_rdy;

    always #5 clk = ~clk;

    ucaspian_neuron dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear_act      (clear_act),
        .clear_act_done (clear_act_done),
        .cfg_addr       (cfg_addr),
        .cfg_threshold  (cfg_threshold),
        .cfg_vld        (cfg_vld),
        .dend_step_done (dend_step_done),
        .step_done      (step_done),
        .neuron_addr    (neuron_addr),
        .neuron_charge  (neuron_charge),
        .neuron_vld     (neuron_vld),
        .neuron_rdy     (neuron_rdy),
        .fire_addr      (fire_addr),
        .fire_vld       (fire_vld),
        .fire_rdy       (fire_rdy)
    );

    int errors = 0;
    int checks = 0;
    int model_pot [256];
    int model_thr [256];
    logic [7:0] expq [$];
    bit rand_bp = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference behaviour: saturating accumulate, fire on reaching threshold.
    function automatic void model_apply(input int a, input int c);
        int s;
        s = model_pot[a] + c;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (s >= model_thr[a]) begin
            model_pot[a] = 0;
            expq.push_back(a[7:0]);
        end else begin
            model_pot[a] = s;
        end
    endfunction

    // Present one input and hold it until accepted (bounded).
    task automatic send(input int a, input int c);
        int n;
        neuron_addr   = a[7:0];
        neuron_charge = c[15:0];
        neuron_vld    = 1'b1;
        n = 0;
        while (!neuron_rdy && n < 300) begin
            @(negedge clk);
            if (rand_bp) fire_rdy = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (!neuron_rdy) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: addr=%0d got rdy=0 required rdy=1", a);
            neuron_vld = 1'b0;
            return;
        end
        model_apply(a, c);
        @(negedge clk);
        neuron_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        repeat (4) @(negedge clk);
        n = 0;
        while ((expq.size() != 0 || fire_vld) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0 || fire_vld) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d fire_vld=%0b required 0/0", expq.size(), fire_vld);
        end
    endtask

    // Full activity clear; checks one done pulse at the expected distance.
    task automatic do_clear();
        int dones;
        int first;
        dones = 0;
        first = -1;
        clear_act = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (clear_act_done) begin
                dones++;
                if (first < 0) first = i + 1;
            end
        end
        clear_act = 1'b0;
        check("clear_done_count", dones, 1);
        checks++;
        if (first < 258 || first > 264) begin
            errors++;
            $display("FAIL clear_duration: got %0d cycles required 258..264", first);
        end
        for (int a = 0; a < 256; a++) model_pot[a] = 0;
        @(negedge clk);
    endtask

    // Monitor: compare every popped fire address against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (reset_n && fire_vld && fire_rdy) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL fire_unexpected: got addr=%0d required none", fire_addr);
            end else begin
                logic [7:0] exp_a;
                exp_a = expq.pop_front();
                if (fire_addr != exp_a) begin
                    errors++;
                    $display("FAIL fire_addr: got %0d required %0d", fire_addr, exp_a);
                end else begin
                    $display("fire addr=%0d ok", fire_addr);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dones;
        reset_n = 1'b0; enable = 1'b0; clear_act = 1'b0;
        cfg_addr = '0; cfg_threshold = '0; cfg_vld = 1'b0;
        dend_step_done = 1'b0; neuron_addr = '0; neuron_charge = '0;
        neuron_vld = 1'b0; fire_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_neuron_rdy", neuron_rdy, 0);
        check("rst_fire_vld", fire_vld, 0);
        check("rst_fire_addr", fire_addr, 0);
        check("rst_step_done", step_done, 0);
        check("rst_clear_done", clear_act_done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Threshold configuration with a few fixed entries.
        for (int a = 0; a < 256; a++) begin
            model_thr[a] = $urandom_range(0, 255);
            if (a == 5)  model_thr[a] = 10;
            if (a == 7)  model_thr[a] = 100;
            if (a == 1)  model_thr[a] = 255;
            if (a == 9 || a == 10) model_thr[a] = 50;
            cfg_addr = a[7:0];
            cfg_threshold = model_thr[a][7:0];
            cfg_vld = 1'b1;
            @(negedge clk);
        end
        cfg_vld = 1'b0;

        // Aborted sweep: no done pulse; the full sweep must restart at 0.
        dones = 0;
        clear_act = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (clear_act_done) dones++;
        end
        clear_act = 1'b0;
        check("abort_no_done", dones, 0);
        repeat (3) @(negedge clk);
        do_clear();

        enable = 1'b1;
        // Threshold write while enabled must be ignored.
        cfg_addr = 8'd5; cfg_threshold = 8'd0; cfg_vld = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;

        // Threshold crossing and reset-to-zero on fire.
        repeat (3) send(5, 4);
        send(5, 4);
        send(5, 6);
        // Back-to-back bypass, positive and negative.
        send(7, 60); send(7, 60);
        send(7, -60); send(7, -60);
        send(7, 219); send(7, 1);
        // A-B-A pattern across two write stages.
        send(9, 30); send(10, 30); send(9, 30); send(10, 25);
        // Saturation.
        send(1, 32767);
        repeat (5) send(1, -32768);
        send(1, 32767);
        send(1, 256);
        wait_drain();
        dend_step_done = 1'b1;
        @(negedge clk);
        check("step_done_idle", step_done, 1);
        dend_step_done = 1'b0;

        // Random traffic on a small address set with random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int a;
            int c;
            a = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) c = $urandom_range(0, 65535) - 32768;
            else                           c = $urandom_range(0, 400) - 150;
            fire_rdy = ($urandom_range(0, 3) != 0);
            send(a, c);
        end
        rand_bp = 1'b0;
        fire_rdy = 1'b1;
        wait_drain();

        // Backpressure: every input fires while the consumer is stalled.
        fire_rdy = 1'b0;
        dend_step_done = 1'b1;
        for (int i = 0; i < 4; i++) send(20 + i, 300);
        repeat (5) @(negedge clk);
        check("bp_rdy_low", neuron_rdy, 0);
        check("bp_fire_vld", fire_vld, 1);
        check("bp_step_busy", step_done, 0);
        fork
            begin
                for (int i = 4; i < 8; i++) send(20 + i, 300);
            end
            begin
                repeat (10) @(negedge clk);
                check("bp_rdy_held", neuron_rdy, 0);
                fire_rdy = 1'b1;
            end
        join
        wait_drain();
        check("bp_step_done", step_done, 1);
        dend_step_done = 1'b0;

        // Clear with two inputs in flight, then confirm potentials read 0.
        send(30, -5);
        send(31, -5);
        do_clear();
        send(30, model_thr[30]);
        send(31, model_thr[31] - 1);
        send(31, 1);
        wait_drain();

        // Asynchronous reset mid-stream.
        fire_rdy = 1'b0;
        send(40, 300);
        send(41, 300);
        neuron_addr = 8'd42; neuron_charge = 16'd300; neuron_vld = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_fire_vld", fire_vld, 0);
        check("arst_neuron_rdy", neuron_rdy, 0);
        expq.delete();
        neuron_vld = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        fire_rdy = 1'b1;
        @(negedge clk);
        do_clear();
        dend_step_done = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_step_done", step_done, 1);
        dend_step_done = 1'b0;
        send(40, 300);
        wait_drain();

        check("scoreboard_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
